// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage (unidad_fetch).
`default_nettype none

package fetch_pkg;

   typedef enum logic [2:0] {
      INICIO = 3'd0,
      REQ    = 3'd1,
      ESPERA = 3'd2,
      LLENO  = 3'd3,
      ERROR  = 3'd4
   } estado_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] PASO_PC   = 32'd4;

   function automatic logic alineado(input logic [31:0] dir);
      return dir[1:0] == 2'b00;
   endfunction

   function automatic logic [31:0] alinear(input logic [31:0] dir);
      return dir & ~32'h0000_0003;
   endfunction

endpackage

`default_nettype wire

// File: rtl/contador_pc.sv
// Program counter register: redirect load has priority over the post-grant word increment.
`default_nettype none

module contador_pc
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cargar,
   input  logic [31:0] destino,
   input  logic        incrementar,
   output logic [31:0] pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (cargar) begin
         pc <= destino;
      end else if (incrementar) begin
         pc <= pc + PASO_PC;
      end
   end

endmodule

`default_nettype wire

// File: rtl/unidad_fetch.sv
// Instruction fetch stage: one outstanding imem read, one-entry output buffer, redirect input.
// Optional macro DESALINEO_CHECK_EN adds excepcion_o and the ERROR state for misaligned targets.
`default_nettype none

module unidad_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        salto_i,
   input  logic [31:0] destino_i,
`ifdef DESALINEO_CHECK_EN
   output logic        excepcion_o,
`endif
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] instruccion_o,
   output logic [31:0] pc_o
);

   import fetch_pkg::*;

   estado_t     estado;
   logic [31:0] pc;
   logic [31:0] pc_pend;
   logic [31:0] destino_pc;
   logic        descartar;
   logic        salto_valido;
   logic        incrementar_pc;

`ifdef DESALINEO_CHECK_EN
   assign salto_valido = salto_i && alineado(destino_i);
   assign destino_pc   = destino_i;
`else
   assign salto_valido = salto_i;
   assign destino_pc   = alinear(destino_i);
`endif

   assign incrementar_pc = (estado == REQ) && imem_gnt_i && !salto_i;

   contador_pc #(
      .RESET_PC (RESET_PC)
   ) u_contador_pc (
      .clk         (clk_i),
      .rst_n       (rst_n_i),
      .cargar      (salto_valido),
      .destino     (destino_pc),
      .incrementar (incrementar_pc),
      .pc          (pc)
   );

   assign imem_req_o  = (estado == REQ);
   assign imem_addr_o = pc;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         estado        <= INICIO;
         valid_o       <= 1'b0;
         instruccion_o <= NOP_INSTR;
         pc_o          <= RESET_PC;
         pc_pend       <= RESET_PC;
         descartar     <= 1'b0;
`ifdef DESALINEO_CHECK_EN
         excepcion_o   <= 1'b0;
`endif
      end else begin
`ifdef DESALINEO_CHECK_EN
         if (salto_i && !alineado(destino_i)) begin
            estado        <= ERROR;
            excepcion_o   <= 1'b1;
            valid_o       <= 1'b0;
            instruccion_o <= NOP_INSTR;
            descartar     <= 1'b0;
         end else
`endif
         case (estado)
            INICIO: estado <= REQ;
            REQ: begin
               if (imem_gnt_i) begin
                  // A redirect in the grant cycle makes this read stale on arrival
                  pc_pend   <= pc;
                  descartar <= salto_i;
                  estado    <= ESPERA;
               end
            end
            ESPERA: begin
               if (imem_rvalid_i) begin
                  if (descartar || salto_i) begin
                     descartar <= 1'b0;
                     estado    <= REQ;
                  end else begin
                     instruccion_o <= imem_rdata_i;
                     pc_o          <= pc_pend;
                     valid_o       <= 1'b1;
                     estado        <= LLENO;
                  end
               end else if (salto_i) begin
                  descartar <= 1'b1;
               end
            end
            LLENO: begin
               if (salto_i || ready_i) begin
                  valid_o       <= 1'b0;
                  instruccion_o <= NOP_INSTR;
                  estado        <= REQ;
               end
            end
`ifdef DESALINEO_CHECK_EN
            ERROR: begin
               if (salto_i) begin
                  excepcion_o <= 1'b0;
                  estado      <= REQ;
               end
            end
`endif
            default: estado <= INICIO;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_unidad_fetch.sv
// Randomized self-checking bench for unidad_fetch against a program-order delivery model.
`default_nettype none

module tb_unidad_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        salto = 1'b0;
   logic [31:0] destino = 32'h0;
   logic        valid;
   logic        ready = 1'b0;
   logic [31:0] instruccion;
   logic [31:0] pc_out;
`ifdef DESALINEO_CHECK_EN
   logic        excepcion;
`endif

   always #5 clk = ~clk;

   unidad_fetch #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (NOP)
   ) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_gnt_i    (imem_gnt),
      .imem_rvalid_i (imem_rvalid),
      .imem_rdata_i  (imem_rdata),
      .salto_i       (salto),
      .destino_i     (destino),
`ifdef DESALINEO_CHECK_EN
      .excepcion_o   (excepcion),
`endif
      .valid_o       (valid),
      .ready_i       (ready),
      .instruccion_o (instruccion),
      .pc_o          (pc_out)
   );

   int checks = 0;
   int failures = 0;

   task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      checks++;
      if (obs !== esp) begin
         failures++;
         $display("FAIL %s: observed=%h expected=%h", tag, obs, esp);
      end
   endtask

   function automatic logic [31:0] dato_mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   // stimulus knobs (percent probabilities)
   int p_gnt = 100, max_delay = 0, p_ready = 100, p_salto = 0;
   bit chk_ritmo = 0;
   bit fuerza_salto = 0;
   logic [31:0] fuerza_destino = 32'h0;

   // memory model: a single outstanding read
   bit          pend = 0;
   logic [31:0] pend_addr = 32'h0;
   int          pend_cnt = 0;

   // delivery model: address of the next instruction decode must see
   logic [31:0] exp_pc = 32'h0;
   int          entregas = 0, ultimo = 0, ciclo_n = 0;
   bit          vio_envoltura = 0;
   logic [31:0] ultimo_pc = 32'h0;

   logic        prev_req = 0, prev_gnt = 0, prev_salto = 0, prev_valid = 0, prev_ready = 0;
   logic [31:0] prev_addr = 0, prev_instr = 0, prev_pc = 0;

   task automatic ciclo();
      @(negedge clk);
      ciclo_n++;
      if (prev_req && !prev_gnt && !prev_salto) begin
         comprobar("req_estable", imem_req, 1);
         comprobar("addr_estable", imem_addr, prev_addr);
      end
      if (prev_valid && !prev_ready && !prev_salto) begin
         comprobar("valid_mantenido", valid, 1);
         comprobar("instr_estable", instruccion, prev_instr);
         comprobar("pc_estable", pc_out, prev_pc);
      end
      if (!valid) comprobar("nop_sin_valid", instruccion, NOP);
      if (valid) comprobar("sin_req_con_valid", imem_req, 0);
      if (imem_req) comprobar("addr_alineada", imem_addr[1:0], 0);

      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (pend) begin
         if (pend_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = dato_mem(pend_addr);
            pend = 0;
         end else begin
            pend_cnt--;
         end
      end
      imem_gnt = imem_req && !pend && ($urandom_range(0, 99) < p_gnt);
      if (imem_gnt) begin
         pend      = 1;
         pend_addr = imem_addr;
         pend_cnt  = $urandom_range(0, max_delay);
      end
      ready = ($urandom_range(0, 99) < p_ready);
      if (fuerza_salto) begin
         salto   = 1'b1;
         destino = fuerza_destino;
         fuerza_salto = 0;
      end else begin
         salto = ($urandom_range(0, 99) < p_salto);
         if ($urandom_range(0, 3) == 0) destino = 32'hFFFF_FFF0 + $urandom_range(0, 15);
         else                           destino = $urandom_range(0, 1023);
`ifdef DESALINEO_CHECK_EN
         destino = destino & ~32'h3;
`endif
      end

      if (valid && ready) begin
         comprobar("pc_entregado", pc_out, exp_pc);
         comprobar("instr_entregada", instruccion, dato_mem(exp_pc));
         if (chk_ritmo && entregas > 0) comprobar("ritmo_3_ciclos", ciclo_n - ultimo, 3);
         if (entregas > 0 && ultimo_pc == 32'hFFFF_FFFC && pc_out == 32'h0) vio_envoltura = 1;
         ultimo    = ciclo_n;
         ultimo_pc = pc_out;
         entregas++;
         exp_pc = exp_pc + 32'd4;
      end
      if (salto) exp_pc = destino & ~32'h3;

      prev_req   = imem_req;   prev_addr  = imem_addr;  prev_gnt = imem_gnt;
      prev_salto = salto;      prev_valid = valid;      prev_ready = ready;
      prev_instr = instruccion; prev_pc   = pc_out;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      comprobar("rst_valid", valid, 0);
      comprobar("rst_instr", instruccion, NOP);
      comprobar("rst_pc", pc_out, 32'h0);
      comprobar("rst_req", imem_req, 0);
`ifdef DESALINEO_CHECK_EN
      comprobar("rst_excepcion", excepcion, 0);
`endif
      rst_n = 1'b1;

      // back-to-back fetch with an ideal memory and consumer
      chk_ritmo = 1;
      repeat (13) ciclo();
      comprobar("entregas_fase1", entregas, 4);
      chk_ritmo = 0;

      // random memory latency, backpressure and redirects
      p_gnt = 60; max_delay = 3; p_ready = 50; p_salto = 8;
      repeat (3000) ciclo();
      comprobar("entregas_minimas", entregas >= 100, 1);

      // wrap of the PC past the top of the address space
      p_gnt = 80; max_delay = 1; p_ready = 100; p_salto = 0;
      fuerza_salto = 1; fuerza_destino = 32'hFFFF_FFF8;
      repeat (40) ciclo();
      comprobar("envoltura_vista", vio_envoltura, 1);

`ifdef DESALINEO_CHECK_EN
      fuerza_salto = 1; fuerza_destino = 32'h0000_0102;
      ciclo();
      repeat (6) begin
         ciclo();
         comprobar("error_excepcion", excepcion, 1);
         comprobar("error_sin_req", imem_req, 0);
         comprobar("error_sin_valid", valid, 0);
      end
      fuerza_salto = 1; fuerza_destino = 32'h0000_0200;
      begin
         int antes;
         antes = entregas;
         repeat (20) ciclo();
         comprobar("excepcion_borrada", excepcion, 0);
         comprobar("entregas_tras_error", entregas > antes, 1);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
